// File: rtl/sha2_pkg.sv
// Shared types, rotation amounts and word-packing helpers for the SHA-2 round engine.
package sha2_pkg;

  localparam int unsigned ROUNDS_32_DEF = 64;
  localparam int unsigned ROUNDS_64_DEF = 80;

  localparam int unsigned S0_ROT32_A = 2;
  localparam int unsigned S0_ROT32_B = 13;
  localparam int unsigned S0_ROT32_C = 22;
  localparam int unsigned S1_ROT32_A = 6;
  localparam int unsigned S1_ROT32_B = 11;
  localparam int unsigned S1_ROT32_C = 25;

  localparam int unsigned S0_ROT64_A = 28;
  localparam int unsigned S0_ROT64_B = 34;
  localparam int unsigned S0_ROT64_C = 39;
  localparam int unsigned S1_ROT64_A = 14;
  localparam int unsigned S1_ROT64_B = 18;
  localparam int unsigned S1_ROT64_C = 41;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  // Lane 7 is working variable a, lane 0 is h; each lane is 64 bits wide.
  typedef logic [7:0][63:0] words_t;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic words_t unpack_words(input logic [511:0] v, input logic mode);
    words_t r;
    for (int i = 0; i < 8; i++) begin
      r[i] = mode ? v[64*i +: 64] : {32'h0, v[32*i +: 32]};
    end
    return r;
  endfunction

  function automatic logic [511:0] pack_words(input words_t s, input logic mode);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (mode) r[64*i +: 64] = s[i];
      else      r[32*i +: 32] = s[i][31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha2_round_engine_if.sv
// Bus between schedule source, round engine and digest consumer.
// The trunc signal exists only when SHA2_ROUND_TRUNC_EN is defined.
interface sha2_round_engine_if #(
  parameter int unsigned IDX_W = 7
);
  logic             start;
  logic             mode;
  logic [511:0]     H_in;
  logic [63:0]      K;
  logic [63:0]      W;
  logic             kw_valid;
  logic             kw_ready;
  logic [IDX_W-1:0] round_idx;
  logic             busy;
  logic [511:0]     hash_out;
  logic             hash_valid;
  logic             hash_ready;
`ifdef SHA2_ROUND_TRUNC_EN
  logic             trunc;
`endif

  modport master (
    output start, mode, H_in, K, W, kw_valid, hash_ready,
`ifdef SHA2_ROUND_TRUNC_EN
    output trunc,
`endif
    input  kw_ready, round_idx, busy, hash_out, hash_valid
  );

  modport slave (
    input  start, mode, H_in, K, W, kw_valid, hash_ready,
`ifdef SHA2_ROUND_TRUNC_EN
    input  trunc,
`endif
    output kw_ready, round_idx, busy, hash_out, hash_valid
  );

endinterface

// File: rtl/sha2_round_step.sv
// Combinational single SHA-2 compression round over a..h.
// Words sit in 64-bit lanes; in 32-bit mode the upper halves stay zero.
module sha2_round_step
  import sha2_pkg::*;
(
  input  logic        mode,
  input  words_t      work,
  input  logic [63:0] k,
  input  logic [63:0] w,
  output words_t      work_next
);

  logic [63:0] a, b, c, d, e, f, g, h;
  logic [63:0] ch, maj, t1_64, t2_64;
  logic [31:0] t1_32, t2_32;

  assign {a, b, c, d, e, f, g, h} = work;

  assign ch  = (e & f) ^ (~e & g);
  assign maj = (a & b) ^ (a & c) ^ (b & c);

  assign t1_64 = h + (rotr64(e, S1_ROT64_A) ^ rotr64(e, S1_ROT64_B) ^ rotr64(e, S1_ROT64_C))
               + ch + k + w;
  assign t2_64 = (rotr64(a, S0_ROT64_A) ^ rotr64(a, S0_ROT64_B) ^ rotr64(a, S0_ROT64_C)) + maj;

  assign t1_32 = h[31:0]
               + (rotr32(e[31:0], S1_ROT32_A) ^ rotr32(e[31:0], S1_ROT32_B)
                  ^ rotr32(e[31:0], S1_ROT32_C))
               + ch[31:0] + k[31:0] + w[31:0];
  assign t2_32 = (rotr32(a[31:0], S0_ROT32_A) ^ rotr32(a[31:0], S0_ROT32_B)
                  ^ rotr32(a[31:0], S0_ROT32_C))
               + maj[31:0];

  always_comb begin
    work_next = {64'h0, work[7:5], 64'h0, work[3:1]};
    if (mode) begin
      work_next[7] = t1_64 + t2_64;
      work_next[3] = d + t1_64;
    end else begin
      work_next[7] = {32'h0, t1_32 + t2_32};
      work_next[3] = {32'h0, d[31:0] + t1_32};
    end
  end

endmodule

// File: rtl/sha2_round_engine.sv
// Iterative SHA-2 compression core: one round per accepted K/W, then feed-forward and digest.
// Define SHA2_ROUND_TRUNC_EN to add the trunc input (SHA-224/SHA-384 length digests).
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter int unsigned ROUNDS_32 = ROUNDS_32_DEF,
  parameter int unsigned ROUNDS_64 = ROUNDS_64_DEF,
  parameter int unsigned IDX_W     = 7
) (
  input logic                clk,
  input logic                rst,
  sha2_round_engine_if.slave bus
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             trunc_q, trunc_d;
  logic             req_trunc;
  words_t           h_q, h_d;
  words_t           work_q, work_d, work_step;
  words_t           sum;
  logic [IDX_W-1:0] idx_q, idx_d, last_idx;
  logic [511:0]     hash_q, hash_d;

`ifdef SHA2_ROUND_TRUNC_EN
  assign req_trunc = bus.trunc;
`else
  assign req_trunc = 1'b0;
`endif

  assign last_idx = mode_q ? IDX_W'(ROUNDS_64 - 1) : IDX_W'(ROUNDS_32 - 1);

  sha2_round_step u_step (
    .mode      (mode_q),
    .work      (work_q),
    .k         (bus.K),
    .w         (bus.W),
    .work_next (work_step)
  );

  // Feed-forward; truncated lanes are zeroed before packing.
  always_comb begin
    for (int i = 0; i < 8; i++) sum[i] = h_q[i] + work_q[i];
    if (trunc_q) begin
      sum[0] = '0;
      if (mode_q) sum[1] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    trunc_d = trunc_q;
    h_d     = h_q;
    work_d  = work_q;
    idx_d   = idx_q;
    hash_d  = hash_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          trunc_d = req_trunc;
          h_d     = unpack_words(bus.H_in, bus.mode);
          work_d  = unpack_words(bus.H_in, bus.mode);
          idx_d   = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        if (bus.kw_valid) begin
          work_d = work_step;
          idx_d  = idx_q + 1'b1;
          if (idx_q == last_idx) state_d = StFinal;
        end
      end
      StFinal: begin
        hash_d  = pack_words(sum, mode_q);
        state_d = StDone;
      end
      StDone: begin
        if (bus.hash_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      trunc_q <= 1'b0;
      h_q     <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      trunc_q <= trunc_d;
      h_q     <= h_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
    end
  end

  assign bus.kw_ready   = (state_q == StRound);
  assign bus.busy       = (state_q != StIdle);
  assign bus.hash_valid = (state_q == StDone);
  assign bus.round_idx  = idx_q;
  assign bus.hash_out   = hash_q;

endmodule
